// File: rtl/led_pkg.sv
// Shared types for the LED command scheduler: mode constants, FSM states and the latched command.
package led_pkg;

    typedef logic [7:0] led_mode_t;

    localparam led_mode_t LED_MODE_SINGLE = 8'd0;
    localparam led_mode_t LED_MODE_BLINK  = 8'd1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FIRE
    } sched_state_t;

    typedef struct packed {
        logic [7:0] led;
        led_mode_t  mode;
        logic       stop;
    } led_cmd_t;

endpackage

// File: rtl/led_cmd_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first eligible index at or after ptr, wrapping at N.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          valid
);

    always_comb begin
        logic [IW-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            idx = IW'((int'(ptr) + k) % N);
            if (!valid && eligible[idx]) begin
                valid      = 1'b1;
                grant_idx  = idx;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_cmd_scheduler.sv
// Round-robin LED command front end with per-LED start guard timers.
// Optional accepted-start statistics are built when LED_SCHED_STATS_EN is defined.
//
// state | meaning
// IDLE  | arbitrate eligible requesters, latch winner, commit mode bus
// LOAD  | command latched; mode bus settled, prepare pulses
// FIRE  | ack/start/stop/cmd_err high; guard loaded or cleared
module led_cmd_scheduler
    import led_pkg::*;
#(
    parameter int LED_NUM     = 4,
    parameter int REQ_NUM     = 4,
    parameter int SYSCLK_RATE = 100,
    parameter int GUARD_MS    = 200
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [REQ_NUM-1:0]            req,
    input  logic [REQ_NUM-1:0][7:0]       req_led,
    input  logic [REQ_NUM-1:0][7:0]       req_mode,
    input  logic [REQ_NUM-1:0]            req_stop,
    output logic [REQ_NUM-1:0]            ack,
    output logic                          cmd_err,
    output logic [LED_NUM-1:0][7:0]       led_mode,
    output logic [LED_NUM-1:0]            led_start,
    output logic [LED_NUM-1:0]            led_stop,
    output logic                          busy,
    output logic [LED_NUM-1:0][15:0]      stat_cnt
);

    localparam int GUARD_CYCLES = SYSCLK_RATE * 1000 * GUARD_MS;
    localparam int GW = $clog2(GUARD_CYCLES + 1);
    localparam int RW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
    localparam int LW = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;

    sched_state_t              state_q, state_d;
    led_cmd_t                  cmd_q, cmd_d;
    logic [REQ_NUM-1:0]        win_q, win_d;
    logic [RW-1:0]             ptr_q, ptr_d;
    logic [LED_NUM-1:0][GW-1:0] guard_q, guard_d;
    logic [LED_NUM-1:0][7:0]   mode_q, mode_d;
    logic [REQ_NUM-1:0]        ack_q, ack_d;
    logic                      err_q, err_d;
    logic [LED_NUM-1:0]        start_q, start_d;
    logic [LED_NUM-1:0]        stop_q, stop_d;

    logic [REQ_NUM-1:0]        eligible;
    logic [REQ_NUM-1:0]        arb_grant;
    logic [RW-1:0]             arb_idx;
    logic                      arb_valid;
    led_cmd_t                  arb_cmd;
    logic                      cmd_valid;

    // Out-of-range LEDs never match a guard, so they are always eligible.
    always_comb begin
        logic [REQ_NUM-1:0] blocked;
        blocked  = '0;
        eligible = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            for (int k = 0; k < LED_NUM; k++) begin
                if (req_led[i] == 8'(k) && guard_q[k] != '0) blocked[i] = 1'b1;
            end
            eligible[i] = req[i] && (req_stop[i] || !blocked[i]);
        end
    end

    rr_arbiter #(.N(REQ_NUM), .IW(RW)) u_arb (
        .eligible  (eligible),
        .ptr       (ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .valid     (arb_valid)
    );

    assign arb_cmd   = '{led: req_led[arb_idx], mode: req_mode[arb_idx], stop: req_stop[arb_idx]};
    assign cmd_valid = (int'(cmd_q.led) < LED_NUM);

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        win_d   = win_q;
        ptr_d   = ptr_q;
        mode_d  = mode_q;
        ack_d   = '0;
        err_d   = 1'b0;
        start_d = '0;
        stop_d  = '0;
        for (int k = 0; k < LED_NUM; k++) begin
            guard_d[k] = (guard_q[k] != '0) ? guard_q[k] - 1'b1 : '0;
        end
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    cmd_d   = arb_cmd;
                    win_d   = arb_grant;
                    ptr_d   = (arb_idx == RW'(REQ_NUM - 1)) ? '0 : arb_idx + 1'b1;
                    state_d = LOAD;
                    // Committed on the grant edge so the bus is stable a full cycle before start.
                    if (!arb_cmd.stop && int'(arb_cmd.led) < LED_NUM)
                        mode_d[arb_cmd.led[LW-1:0]] = arb_cmd.mode;
                end
            end
            LOAD: begin
                state_d = FIRE;
                ack_d   = win_q;
                if (!cmd_valid) begin
                    err_d = 1'b1;
                end else if (cmd_q.stop) begin
                    stop_d[cmd_q.led[LW-1:0]] = 1'b1;
                end else begin
                    start_d[cmd_q.led[LW-1:0]] = 1'b1;
                    mode_d[cmd_q.led[LW-1:0]]  = cmd_q.mode;
                end
            end
            FIRE: begin
                state_d = IDLE;
                if (cmd_valid)
                    guard_d[cmd_q.led[LW-1:0]] = cmd_q.stop ? '0 : GW'(GUARD_CYCLES);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            win_q   <= '0;
            ptr_q   <= '0;
            guard_q <= '0;
            for (int k = 0; k < LED_NUM; k++) mode_q[k] <= LED_MODE_SINGLE;
            ack_q   <= '0;
            err_q   <= 1'b0;
            start_q <= '0;
            stop_q  <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            win_q   <= win_d;
            ptr_q   <= ptr_d;
            guard_q <= guard_d;
            mode_q  <= mode_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            start_q <= start_d;
            stop_q  <= stop_d;
        end
    end

    assign ack       = ack_q;
    assign cmd_err   = err_q;
    assign led_mode  = mode_q;
    assign led_start = start_q;
    assign led_stop  = stop_q;
    assign busy      = (state_q != IDLE);

`ifdef LED_SCHED_STATS_EN
    logic [LED_NUM-1:0][15:0] stat_q, stat_d;

    always_comb begin
        stat_d = stat_q;
        for (int k = 0; k < LED_NUM; k++) begin
            if (start_q[k] && stat_q[k] != 16'hFFFF) stat_d[k] = stat_q[k] + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) stat_q <= '0;
        else       stat_q <= stat_d;
    end

    assign stat_cnt = stat_q;
`else
    assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_led_cmd_scheduler.sv
// Directed plus randomized bench for led_cmd_scheduler against an edge-indexed transaction model.
module tb_led_cmd_scheduler;
    import led_pkg::*;

    localparam int LED_NUM = 4;
    localparam int REQ_NUM = 4;
    localparam int SR      = 1;
    localparam int GM      = 1;
    localparam int G       = SR * 1000 * GM;
`ifdef LED_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic [REQ_NUM-1:0]       req, req_stop;
    logic [REQ_NUM-1:0][7:0]  req_led, req_mode;
    logic [REQ_NUM-1:0]       ack;
    logic                     cmd_err;
    logic [LED_NUM-1:0][7:0]  led_mode;
    logic [LED_NUM-1:0]       led_start, led_stop;
    logic                     busy;
    logic [LED_NUM-1:0][15:0] stat_cnt;

    always #5 clk = ~clk;

    led_cmd_scheduler #(
        .LED_NUM(LED_NUM), .REQ_NUM(REQ_NUM), .SYSCLK_RATE(SR), .GUARD_MS(GM)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_led(req_led), .req_mode(req_mode),
        .req_stop(req_stop), .ack(ack), .cmd_err(cmd_err), .led_mode(led_mode),
        .led_start(led_start), .led_stop(led_stop), .busy(busy), .stat_cnt(stat_cnt)
    );

    int errors = 0;
    int checks = 0;

    // Model: edges are numbered; a grant at edge g shows mode after g, pulses after g+1,
    // and the next arbitration happens at g+3. exp_t[led] is the first edge a start may win.
    int cyc;
    int exp_t[LED_NUM];
    int e_mode[LED_NUM];
    int e_stat[LED_NUM];
    int rr, next_arb, fire_edge, busy_last, stat_edge, stat_led;
    int f_idx, f_led;
    bit f_stop;
    logic [REQ_NUM-1:0] e_ack, hold;
    logic [LED_NUM-1:0] e_start, e_stop;
    logic e_err, e_busy;

    task automatic model_reset();
        for (int k = 0; k < LED_NUM; k++) begin
            exp_t[k] = 0; e_mode[k] = 0; e_stat[k] = 0;
        end
        rr = 0; next_arb = 0; fire_edge = -10; busy_last = -10; stat_edge = -10; stat_led = 0;
        e_ack = '0; e_start = '0; e_stop = '0; e_err = 1'b0; e_busy = 1'b0;
    endtask

    task automatic model_edge();
        int w, i;
        e_ack = '0; e_start = '0; e_stop = '0; e_err = 1'b0;
        if (reset) begin
            model_reset();
        end else begin
            if (stat_edge == cyc && e_stat[stat_led] < 65535) e_stat[stat_led]++;
            if (fire_edge == cyc) begin
                e_ack[f_idx] = 1'b1;
                if (f_led >= LED_NUM) e_err = 1'b1;
                else if (f_stop) e_stop[f_led] = 1'b1;
                else begin
                    e_start[f_led] = 1'b1;
                    stat_edge = cyc + 1;
                    stat_led  = f_led;
                end
            end
            w = -1;
            if (cyc >= next_arb) begin
                for (int k = 0; k < REQ_NUM; k++) begin
                    i = (rr + k) % REQ_NUM;
                    if (w < 0 && req[i]) begin
                        if (req_stop[i] || int'(req_led[i]) >= LED_NUM) w = i;
                        else if (exp_t[req_led[i]] <= cyc) w = i;
                    end
                end
            end
            if (w >= 0) begin
                rr = (w + 1) % REQ_NUM;
                fire_edge = cyc + 1;
                busy_last = cyc + 1;
                next_arb  = cyc + 3;
                f_idx  = w;
                f_led  = int'(req_led[w]);
                f_stop = req_stop[w];
                if (f_led < LED_NUM) begin
                    if (f_stop) exp_t[f_led] = cyc + 2;
                    else begin
                        e_mode[f_led] = int'(req_mode[w]);
                        exp_t[f_led]  = cyc + 3 + G;
                    end
                end
            end
            e_busy = (cyc <= busy_last);
        end
        cyc++;
    endtask

    task automatic check_outputs(input string tag);
        logic [LED_NUM-1:0][7:0]  m;
        logic [LED_NUM-1:0][15:0] s;
        for (int k = 0; k < LED_NUM; k++) begin
            m[k] = 8'(e_mode[k]);
            s[k] = STATS ? 16'(e_stat[k]) : 16'h0;
        end
        checks++;
        assert (ack === e_ack) else begin
            errors++; $error("FAIL %s ack: got %h expected %h", tag, ack, e_ack);
        end
        checks++;
        assert (cmd_err === e_err) else begin
            errors++; $error("FAIL %s cmd_err: got %b expected %b", tag, cmd_err, e_err);
        end
        checks++;
        assert (led_start === e_start) else begin
            errors++; $error("FAIL %s led_start: got %h expected %h", tag, led_start, e_start);
        end
        checks++;
        assert (led_stop === e_stop) else begin
            errors++; $error("FAIL %s led_stop: got %h expected %h", tag, led_stop, e_stop);
        end
        checks++;
        assert (busy === e_busy) else begin
            errors++; $error("FAIL %s busy: got %b expected %b", tag, busy, e_busy);
        end
        checks++;
        assert (led_mode === m) else begin
            errors++; $error("FAIL %s led_mode: got %h expected %h", tag, led_mode, m);
        end
        checks++;
        assert (stat_cnt === s) else begin
            errors++; $error("FAIL %s stat_cnt: got %h expected %h", tag, stat_cnt, s);
        end
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    // Directed step: requesters not marked hold drop req once acked.
    task automatic dtick(input string tag, input int n);
        for (int j = 0; j < n; j++) begin
            tick(tag);
            for (int i = 0; i < REQ_NUM; i++) if (e_ack[i] && !hold[i]) req[i] = 1'b0;
        end
    endtask

    task automatic set_req(input int i, input int led, input int mode, input bit stop);
        req[i] = 1'b1; req_led[i] = 8'(led); req_mode[i] = 8'(mode); req_stop[i] = stop;
    endtask

    task automatic rand_update();
        for (int i = 0; i < REQ_NUM; i++) begin
            if (e_ack[i]) begin
                if ($urandom_range(1, 0) == 1)
                    set_req(i, $urandom_range(5, 0), $urandom_range(3, 0), $urandom_range(99, 0) < 30);
                else
                    req[i] = 1'b0;
            end else if (!req[i]) begin
                if ($urandom_range(99, 0) < 25)
                    set_req(i, $urandom_range(5, 0), $urandom_range(3, 0), $urandom_range(99, 0) < 30);
            end else if ($urandom_range(99, 0) < 2) begin
                req[i] = 1'b0;
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        req = '0; req_stop = '0; req_led = '0; req_mode = '0; hold = '0;
        cyc = 0;
        model_reset();
        dtick("reset", 2);
        reset = 1'b0;
        dtick("idle", 2);

        // All four starts at once, then all four stops: both rounds begin at requester 0.
        for (int i = 0; i < REQ_NUM; i++) set_req(i, i, 2, 1'b0);
        dtick("rr_start", 14);
        for (int i = 0; i < REQ_NUM; i++) set_req(i, i, 0, 1'b1);
        dtick("rr_stop", 14);

        set_req(0, 0, LED_MODE_BLINK, 1'b0);
        dtick("single", 5);

        set_req(1, 7, 9, 1'b0);
        dtick("bad_led", 5);

        // Guard: requester 0 keeps retriggering LED 2; requester 1 stops it mid-guard.
        hold[0] = 1'b1;
        set_req(0, 2, 1, 1'b0);
        dtick("guard", 60);
        set_req(1, 2, 0, 1'b1);
        dtick("guard_stop", 10);
        dtick("guard_wait", G + 20);
        hold[0] = 1'b0;
        req[0] = 1'b0;
        dtick("guard_end", 4);

        // Three starts to LED 1, each cleared by a stop in between.
        for (int r = 0; r < 3; r++) begin
            set_req(2, 1, r, 1'b0);
            dtick("stat_start", 5);
            set_req(2, 1, 0, 1'b1);
            dtick("stat_stop", 5);
        end

        // Reset while the command is in LOAD: aborted, then re-served after release.
        set_req(3, 3, 1, 1'b0);
        tick("pre_abort");
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs("async_reset");
        dtick("in_reset", 2);
        reset = 1'b0;
        dtick("reserve", 6);

        req = '0;
        dtick("drain", 4);
        for (int n = 0; n < 4000; n++) begin
            tick("random");
            rand_update();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
